// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: keypad code lock FSM with entry timeout, reprogramming and attempt lockout.
// Define LOCK_ALARM_EN to drive alarm from lockout; the entered-code port is named seq because sequence is a keyword.
module code_lock_ctrl #(
   parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
   parameter int          TIMEOUT_CYCLES = 1000,
   parameter int          UNLOCK_CYCLES  = 5000,
   parameter int          LOCKOUT_CYCLES = 20000,
   parameter int          MAX_ATTEMPTS   = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_pressed,
   input  logic [15:0] seq,
   input  logic        new_seq,
   input  logic        prog_mode,
   output logic        times_up,
   output logic        unlocked,
   output logic        code_saved,
   output logic [1:0]  attempts,
   output logic        lockout,
   output logic        alarm
);
   localparam int MAXC = (TIMEOUT_CYCLES > UNLOCK_CYCLES)
                       ? ((TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES)
                       : ((UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES);
   localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [TW-1:0] T_LD = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] U_LD = TW'(UNLOCK_CYCLES - 1);
   localparam logic [TW-1:0] L_LD = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [1:0]    MA   = 2'(MAX_ATTEMPTS);
   typedef enum logic [1:0] {LOCKED, UNLOCKED, PROGRAM, LOCKOUT} state_t;
   state_t          state;
   logic [15:0]     stored_code;
   logic [TW-1:0]   win_cnt;
   logic [TW-1:0]   ent_cnt;
   logic            ent_armed;
   logic [2:0]      disc;
   logic            ns;
   logic            cmp;
   logic [1:0]      att_nx;
   // A new_seq inside the post-timeout window is swallowed entirely
   assign ns     = new_seq && disc == 3'd0;
   assign cmp    = ns && (state == LOCKED || (state == UNLOCKED && win_cnt == '0));
   assign att_nx = attempts + 2'd1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= LOCKED;
         stored_code <= DEFAULT_CODE;
         win_cnt     <= '0;
         ent_cnt     <= '0;
         ent_armed   <= 1'b0;
         disc        <= 3'd0;
         times_up    <= 1'b0;
         unlocked    <= 1'b0;
         code_saved  <= 1'b0;
         attempts    <= 2'd0;
         lockout     <= 1'b0;
      end else begin
         times_up   <= 1'b0;
         code_saved <= 1'b0;
         if (disc != 3'd0) disc <= new_seq ? 3'd0 : disc - 3'd1;
         if (new_seq) ent_armed <= 1'b0;
         else if (key_pressed && state != LOCKOUT) begin
            ent_armed <= 1'b1;
            ent_cnt   <= T_LD;
         end else if (ent_armed) begin
            if (ent_cnt == '0) begin
               ent_armed <= 1'b0;
               times_up  <= 1'b1;
               disc      <= 3'd5;
            end else ent_cnt <= ent_cnt - TW'(1);
         end
         case (state)
            UNLOCKED:
               if (win_cnt == '0) begin
                  unlocked <= 1'b0;
                  state    <= LOCKED;
               end else begin
                  win_cnt <= win_cnt - TW'(1);
                  if (ns) begin
                     unlocked <= 1'b0;
                     state    <= prog_mode ? PROGRAM : LOCKED;
                  end
               end
            PROGRAM:
               if (ns) begin
                  state <= LOCKED;
                  if (seq != 16'hFFFF && seq != 16'h0000) begin
                     stored_code <= seq;
                     code_saved  <= 1'b1;
                  end
               end
            LOCKOUT:
               if (win_cnt == '0) begin
                  state    <= LOCKED;
                  lockout  <= 1'b0;
                  attempts <= 2'd0;
               end else win_cnt <= win_cnt - TW'(1);
            default: ;
         endcase
         // Compare overrides the UNLOCKED expiry so a coincident entry acts as a LOCKED one
         if (cmp) begin
            if (seq == stored_code) begin
               state    <= UNLOCKED;
               unlocked <= 1'b1;
               attempts <= 2'd0;
               win_cnt  <= U_LD;
            end else begin
               attempts <= att_nx;
               if (att_nx == MA) begin
                  state   <= LOCKOUT;
                  lockout <= 1'b1;
                  win_cnt <= L_LD;
               end
            end
         end
      end
   end
`ifdef LOCK_ALARM_EN
   assign alarm = lockout;
`else
   assign alarm = 1'b0;
`endif
endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb_code_lock_ctrl: directed self-checking bench for code_lock_ctrl with shortened timers.
module tb_code_lock_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_pressed = 1'b0;
   logic [15:0] seq = 16'h0000;
   logic        new_seq = 1'b0;
   logic        prog_mode = 1'b0;
   logic        times_up, unlocked, code_saved, lockout, alarm;
   logic [1:0]  attempts;
   int vecs = 0;
   int errs = 0;
`ifdef LOCK_ALARM_EN
   localparam logic ALARM_EXP = 1'b1;
`else
   localparam logic ALARM_EXP = 1'b0;
`endif
   code_lock_ctrl #(
      .DEFAULT_CODE(16'h1234), .TIMEOUT_CYCLES(8), .UNLOCK_CYCLES(16),
      .LOCKOUT_CYCLES(32), .MAX_ATTEMPTS(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_pressed(key_pressed), .seq(seq),
      .new_seq(new_seq), .prog_mode(prog_mode), .times_up(times_up),
      .unlocked(unlocked), .code_saved(code_saved), .attempts(attempts),
      .lockout(lockout), .alarm(alarm)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic enter(input logic [15:0] c);
      seq = c;
      new_seq = 1'b1;
      tick();
      new_seq = 1'b0;
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      vecs++; if ({times_up, unlocked, code_saved, lockout, alarm} !== 5'b0) begin errs++; $display("FAIL reset_outs got=%b exp=00000", {times_up, unlocked, code_saved, lockout, alarm}); end
      vecs++; if (attempts !== 2'd0) begin errs++; $display("FAIL reset_attempts got=%0d exp=0", attempts); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask
   task automatic test_unlock();
      enter(16'h1234);
      vecs++; if (unlocked !== 1'b1) begin errs++; $display("FAIL unlock_open got=%b exp=1", unlocked); end
      vecs++; if (attempts !== 2'd0) begin errs++; $display("FAIL unlock_attempts got=%0d exp=0", attempts); end
      for (int i = 0; i < 15; i++) begin
         tick();
         vecs++; if (unlocked !== 1'b1) begin errs++; $display("FAIL unlock_hold cyc=%0d got=%b exp=1", i + 2, unlocked); end
      end
      tick();
      vecs++; if (unlocked !== 1'b0) begin errs++; $display("FAIL unlock_expire got=%b exp=0", unlocked); end
   endtask
   task automatic test_lockout();
      enter(16'h1111);
      vecs++; if (attempts !== 2'd1) begin errs++; $display("FAIL lock_att1 got=%0d exp=1", attempts); end
      enter(16'h1111);
      vecs++; if (attempts !== 2'd2) begin errs++; $display("FAIL lock_att2 got=%0d exp=2", attempts); end
      vecs++; if (lockout !== 1'b0) begin errs++; $display("FAIL lock_early got=%b exp=0", lockout); end
      enter(16'h1111);
      vecs++; if (lockout !== 1'b1) begin errs++; $display("FAIL lock_enter got=%b exp=1", lockout); end
      vecs++; if (alarm !== ALARM_EXP) begin errs++; $display("FAIL lock_alarm got=%b exp=%b", alarm, ALARM_EXP); end
      enter(16'h1234);
      vecs++; if (unlocked !== 1'b0) begin errs++; $display("FAIL lock_ignore got=%b exp=0", unlocked); end
      for (int i = 0; i < 30; i++) begin
         tick();
         vecs++; if (lockout !== 1'b1) begin errs++; $display("FAIL lock_hold cyc=%0d got=%b exp=1", i + 3, lockout); end
      end
      tick();
      vecs++; if (lockout !== 1'b0 || alarm !== 1'b0) begin errs++; $display("FAIL lock_expire got=%b%b exp=00", lockout, alarm); end
      vecs++; if (attempts !== 2'd0) begin errs++; $display("FAIL lock_att_clear got=%0d exp=0", attempts); end
      vecs++; if (unlocked !== 1'b0) begin errs++; $display("FAIL lock_no_unlock got=%b exp=0", unlocked); end
   endtask
   task automatic test_timeout();
      key_pressed = 1'b1;
      tick();
      key_pressed = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         vecs++; if (times_up !== 1'b0) begin errs++; $display("FAIL to_early cyc=%0d got=%b exp=0", i + 1, times_up); end
      end
      tick();
      vecs++; if (times_up !== 1'b1) begin errs++; $display("FAIL to_pulse got=%b exp=1", times_up); end
      tick();
      vecs++; if (times_up !== 1'b0) begin errs++; $display("FAIL to_width got=%b exp=0", times_up); end
      tick();
      enter(16'h1111);
      vecs++; if (attempts !== 2'd0) begin errs++; $display("FAIL to_discard got=%0d exp=0", attempts); end
      enter(16'h1111);
      vecs++; if (attempts !== 2'd1) begin errs++; $display("FAIL to_resume got=%0d exp=1", attempts); end
      enter(16'h1234);
      vecs++; if (unlocked !== 1'b1 || attempts !== 2'd0) begin errs++; $display("FAIL to_unlock got=%b/%0d exp=1/0", unlocked, attempts); end
      enter(16'h0000);
      vecs++; if (unlocked !== 1'b0 || attempts !== 2'd0) begin errs++; $display("FAIL to_relock got=%b/%0d exp=0/0", unlocked, attempts); end
   endtask
   task automatic test_key_wins();
      key_pressed = 1'b1;
      tick();
      key_pressed = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      key_pressed = 1'b1;
      tick();
      key_pressed = 1'b0;
      vecs++; if (times_up !== 1'b0) begin errs++; $display("FAIL kw_suppress got=%b exp=0", times_up); end
      for (int i = 0; i < 7; i++) begin
         tick();
         vecs++; if (times_up !== 1'b0) begin errs++; $display("FAIL kw_early cyc=%0d got=%b exp=0", i + 1, times_up); end
      end
      tick();
      vecs++; if (times_up !== 1'b1) begin errs++; $display("FAIL kw_pulse got=%b exp=1", times_up); end
      for (int i = 0; i < 6; i++) tick();
   endtask
   task automatic test_collision();
      enter(16'h1234);
      for (int i = 0; i < 15; i++) tick();
      enter(16'h1234);
      vecs++; if (unlocked !== 1'b1) begin errs++; $display("FAIL coll_reopen got=%b exp=1", unlocked); end
      for (int i = 0; i < 15; i++) tick();
      enter(16'h2222);
      vecs++; if (unlocked !== 1'b0 || attempts !== 2'd1) begin errs++; $display("FAIL coll_miss got=%b/%0d exp=0/1", unlocked, attempts); end
   endtask
   task automatic test_reprogram();
      enter(16'h1234);
      vecs++; if (unlocked !== 1'b1) begin errs++; $display("FAIL prog_unlock got=%b exp=1", unlocked); end
      prog_mode = 1'b1;
      enter(16'h5678);
      vecs++; if (unlocked !== 1'b0 || code_saved !== 1'b0) begin errs++; $display("FAIL prog_enter got=%b%b exp=00", unlocked, code_saved); end
      enter(16'h5678);
      vecs++; if (code_saved !== 1'b1) begin errs++; $display("FAIL prog_saved got=%b exp=1", code_saved); end
      tick();
      vecs++; if (code_saved !== 1'b0) begin errs++; $display("FAIL prog_pulse got=%b exp=0", code_saved); end
      prog_mode = 1'b0;
      enter(16'h1234);
      vecs++; if (unlocked !== 1'b0 || attempts !== 2'd1) begin errs++; $display("FAIL prog_old got=%b/%0d exp=0/1", unlocked, attempts); end
      enter(16'h5678);
      vecs++; if (unlocked !== 1'b1 || attempts !== 2'd0) begin errs++; $display("FAIL prog_new got=%b/%0d exp=1/0", unlocked, attempts); end
      prog_mode = 1'b1;
      enter(16'h0001);
      enter(16'hFFFF);
      vecs++; if (code_saved !== 1'b0) begin errs++; $display("FAIL prog_reject got=%b exp=0", code_saved); end
      prog_mode = 1'b0;
      enter(16'h5678);
      vecs++; if (unlocked !== 1'b1) begin errs++; $display("FAIL prog_kept got=%b exp=1", unlocked); end
      enter(16'h0000);
      vecs++; if (unlocked !== 1'b0) begin errs++; $display("FAIL prog_relock got=%b exp=0", unlocked); end
   endtask
   task automatic test_reset_lockout();
      enter(16'h1111);
      enter(16'h1111);
      enter(16'h1111);
      vecs++; if (lockout !== 1'b1) begin errs++; $display("FAIL rl_lock got=%b exp=1", lockout); end
      for (int i = 0; i < 5; i++) tick();
      #2 rst_n = 1'b0;
      #1;
      vecs++; if (lockout !== 1'b0 || attempts !== 2'd0) begin errs++; $display("FAIL rl_clear got=%b/%0d exp=0/0", lockout, attempts); end
      tick();
      rst_n = 1'b1;
      tick();
      enter(16'h1234);
      vecs++; if (unlocked !== 1'b1) begin errs++; $display("FAIL rl_default got=%b exp=1", unlocked); end
   endtask
   initial begin
      test_reset();
      test_unlock();
      test_lockout();
      test_timeout();
      test_key_wins();
      test_collision();
      test_reprogram();
      test_reset_lockout();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
